config_wr_sched: RTL

//  Serialises configuration writes from two requesters (ground-command uplink, local sequencer) onto the

---
 rtl/config_wr_sched.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/config_wr_sched.sv
// Round-robin scheduler that serialises configuration writes from the uplink and the
// local sequencer onto the trigger register file port, with legality checks and counters.
module config_wr_sched #(
  parameter logic [7:0]  MAX_ADDR = 8'h13,
  parameter int unsigned GAP_CYC  = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        cmd_valid_in,
  input  logic [7:0]  cmd_addr_in,
  input  logic [15:0] cmd_data_in,
  output logic        cmd_ready_out,
  input  logic        seq_valid_in,
  input  logic [7:0]  seq_addr_in,
  input  logic [15:0] seq_data_in,
  output logic        seq_ready_out,
  output logic        wr_out,
  output logic [7:0]  wr_addr_out,
  output logic [15:0] data_out,
  output logic        lock_out,
  output logic        rej_pulse_out,
  output logic [15:0] acc_cnt_out,
  output logic [15:0] rej_cnt_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [7:0]  LOCK_ADDR   = 8'h00;
  localparam logic [7:0]  FIRST_GATED = 8'h02;
  localparam logic [15:0] LOCK_ON     = 16'h0001;
  localparam logic [15:0] CNT_MAX     = 16'hFFFF;
  localparam logic [3:0]  GAP_LOAD    = 4'(GAP_CYC - 1);

  state_t      state_q, state_d;
  logic        rr_seq_q;      // 1: sequencer has priority at the next grant
  logic        cap_legal_q;   // legality of the request being written this slot
  logic [7:0]  wr_addr_q;
  logic [15:0] data_q;
  logic        lock_q;
  logic [15:0] acc_cnt_q;
  logic [15:0] rej_cnt_q;
  logic [3:0]  gap_cnt_q;

  logic        grant_cmd;
  logic        grant_seq;
  logic        handshake;
  logic [7:0]  req_addr;
  logic [15:0] req_data;
  logic        req_legal;
  logic        do_wr;
  logic        do_rej;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    grant_cmd = 1'b0;
    grant_seq = 1'b0;
    do_wr     = 1'b0;
    do_rej    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rr_seq_q) begin
          grant_seq = seq_valid_in;
          grant_cmd = cmd_valid_in & ~seq_valid_in;
        end else begin
          grant_cmd = cmd_valid_in;
          grant_seq = seq_valid_in & ~cmd_valid_in;
        end
        if (grant_cmd || grant_seq) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        do_wr   = cap_legal_q;
        do_rej  = ~cap_legal_q;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset abandons the slot immediately: no handshake, strobe or pulse while it is high.
    if (rst_in) begin
      grant_cmd = 1'b0;
      grant_seq = 1'b0;
      do_wr     = 1'b0;
      do_rej    = 1'b0;
      state_d   = ST_IDLE;
    end
  end

  assign handshake = grant_cmd | grant_seq;
  assign req_addr  = grant_seq ? seq_addr_in : cmd_addr_in;
  assign req_data  = grant_seq ? seq_data_in : cmd_data_in;
  assign req_legal = (req_addr <= MAX_ADDR) && !(lock_q && (req_addr >= FIRST_GATED));

  // NOTE: all state below uses non-blocking assignments so every register samples the
  // values from before this edge, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      rr_seq_q    <= 1'b0;
      cap_legal_q <= 1'b0;
      wr_addr_q   <= '0;
      data_q      <= '0;
      lock_q      <= 1'b0;
      acc_cnt_q   <= '0;
      rej_cnt_q   <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q <= state_d;

      // Address/data registers only move on a legal request, so a rejected slot leaves
      // the write port showing the previous write.
      if (handshake) begin
        rr_seq_q    <= grant_cmd;
        cap_legal_q <= req_legal;
        if (req_legal) begin
          wr_addr_q <= req_addr;
          data_q    <= req_data;
        end
      end

      if (state_q == ST_WRITE) begin
        gap_cnt_q <= GAP_LOAD;
      end else if ((state_q == ST_GAP) && (gap_cnt_q != '0)) begin
        gap_cnt_q <= gap_cnt_q - 4'd1;
      end

      if (do_wr) begin
        if (acc_cnt_q != CNT_MAX) acc_cnt_q <= acc_cnt_q + 16'd1;
        if (wr_addr_q == LOCK_ADDR) lock_q <= (data_q == LOCK_ON);
      end

      if (do_rej && (rej_cnt_q != CNT_MAX)) rej_cnt_q <= rej_cnt_q + 16'd1;
    end
  end

  assign cmd_ready_out = grant_cmd;
  assign seq_ready_out = grant_seq;
  assign wr_out        = do_wr;
  assign rej_pulse_out = do_rej;
  assign wr_addr_out   = wr_addr_q;
  assign data_out      = data_q;
  assign lock_out      = lock_q;
  assign acc_cnt_out   = acc_cnt_q;
  assign rej_cnt_out   = rej_cnt_q;

endmodule
